// File: rtl/i2c_csr_bridge_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_csr_pkg : shared types and widths for the I2C-to-CSR bridge
// Rev 1.0
// ----------------------------------------------------------------------------
package i2c_csr_pkg;

  localparam int CSR_AW = 5;
  localparam int CSR_DW = 8;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    ADDR_ACK = 4'd2,
    PTR      = 4'd3,
    WR_DATA  = 4'd4,
    WR_ACK   = 4'd5,
    RD_DATA  = 4'd6,
    RD_ACK   = 4'd7,
    IGNORE   = 4'd8
  } state_e;

endpackage
`default_nettype wire

// File: rtl/i2c_csr_bridge_line_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_line_filter : 2-FF synchronizer, glitch filter and edge pulses for one line
// Rev 1.0
// ----------------------------------------------------------------------------
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic          rise_q;
  logic          fall_q;
  logic [CW-1:0] cnt_q;

  // A new level is accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], pin_i};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_q <= sync_q[1];
        rise_q  <= sync_q[1];
        fall_q  <= ~sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule
`default_nettype wire

// File: rtl/i2c_csr_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_csr_bridge : I2C target that masters the CSR bus with an auto-incrementing pointer
// Rev 1.0
// ----------------------------------------------------------------------------
module i2c_csr_bridge
  import i2c_csr_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR   = 7'h4a,
  parameter int         FILTER_LEN = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic [CSR_AW-1:0] csr_a,
  output logic [CSR_DW-1:0] csr_di,
  output logic              csr_we,
  input  logic [CSR_DW-1:0] csr_do
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .pin_i   (scl_i),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .pin_i   (sda_i),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  logic w_start, w_stop;
  assign w_start = sda_fall & scl_lvl;
  assign w_stop  = sda_rise & scl_lvl;

  state_e            state_q;
  logic [2:0]        bitcnt_q;
  logic [CSR_DW-1:0] shift_q;
  logic              byte_done_q;
  logic              rw_q;
  logic              mack_q;
  logic [CSR_AW-1:0] ptr_q;
  logic [CSR_DW-1:0] csr_di_q;
  logic              csr_we_q;
  logic              sda_oe_q;

  logic [CSR_DW-1:0] w_byte;
  assign w_byte = {shift_q[CSR_DW-2:0], sda_lvl};

  // Received bytes complete on the 8th SCL rise; the ACK/next-state decision
  // waits for the following SCL fall so sda_oe only ever moves while SCL is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      byte_done_q <= 1'b0;
      rw_q        <= 1'b0;
      mack_q      <= 1'b1;
      ptr_q       <= '0;
      csr_di_q    <= '0;
      csr_we_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
    end else begin
      csr_we_q <= 1'b0;
      if (csr_we_q) ptr_q <= ptr_q + CSR_AW'(1);

      if (w_start) begin
        state_q     <= ADDR;
        bitcnt_q    <= '0;
        byte_done_q <= 1'b0;
        sda_oe_q    <= 1'b0;
      end else if (w_stop) begin
        state_q     <= IDLE;
        bitcnt_q    <= '0;
        byte_done_q <= 1'b0;
        sda_oe_q    <= 1'b0;
      end else if (scl_rise) begin
        case (state_q)
          ADDR, PTR, WR_DATA: begin
            shift_q  <= w_byte;
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              byte_done_q <= 1'b1;
              if (state_q == PTR) ptr_q <= w_byte[CSR_AW-1:0];
              if (state_q == WR_DATA) begin
                csr_di_q <= w_byte;
                csr_we_q <= 1'b1;
              end
            end
          end
          RD_DATA: begin
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) byte_done_q <= 1'b1;
          end
          RD_ACK:  mack_q <= sda_lvl;
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state_q)
          ADDR: begin
            if (byte_done_q) begin
              byte_done_q <= 1'b0;
              if (shift_q[7:1] == I2C_ADDR) begin
                state_q  <= ADDR_ACK;
                sda_oe_q <= 1'b1;
                rw_q     <= shift_q[0];
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          PTR, WR_DATA: begin
            if (byte_done_q) begin
              byte_done_q <= 1'b0;
              sda_oe_q    <= 1'b1;
              state_q     <= WR_ACK;
            end
          end
          WR_ACK: begin
            sda_oe_q <= 1'b0;
            state_q  <= WR_DATA;
          end
          RD_DATA: begin
            if (byte_done_q) begin
              byte_done_q <= 1'b0;
              sda_oe_q    <= 1'b0;
              state_q     <= RD_ACK;
            end else begin
              shift_q  <= {shift_q[CSR_DW-2:0], 1'b0};
              sda_oe_q <= ~shift_q[CSR_DW-2];
            end
          end
          ADDR_ACK, RD_ACK: begin
            // Read byte is captured here; later CSR changes do not alter it.
            if ((state_q == ADDR_ACK && rw_q) || (state_q == RD_ACK && !mack_q)) begin
              shift_q  <= csr_do;
              sda_oe_q <= ~csr_do[CSR_DW-1];
              ptr_q    <= ptr_q + CSR_AW'(1);
              bitcnt_q <= '0;
              state_q  <= RD_DATA;
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= (state_q == ADDR_ACK) ? PTR : IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe = sda_oe_q;
  assign csr_a  = ptr_q;
  assign csr_di = csr_di_q;
  assign csr_we = csr_we_q;

endmodule
`default_nettype wire
